fft_output_packer: RTL and testbench

//  Downstream of the FFT core: collects one 2048-sample frame of 16-bit results arriving one

---
 rtl/fft_output_packer.sv | 127 ++++++++++++
 tb/tb_fft_output_packer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_output_packer.sv
// fft_output_packer: collects one frame of FFT result samples, one per handshake,
// and packs them into wide lines for the memory write-back path. Sample n lands in
// line n/SAMPLES_PER_LINE, lane n%SAMPLES_PER_LINE. A packing register accumulates
// the lower lanes while one output register holds a finished line, so input keeps
// flowing while a line waits for downstream.
module fft_output_packer #(
    parameter int SAMPLE_W      = 16,
    parameter int LINE_W        = 512,
    parameter int FRAME_SAMPLES = 2048,
    localparam int SPL          = LINE_W / SAMPLE_W,
    localparam int LPF          = FRAME_SAMPLES / SPL,
    localparam int LANE_W       = $clog2(SPL),
    localparam int LINE_IDX_W   = $clog2(LPF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SAMPLE_W-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LINE_W-1:0]     out_data,
    output logic [LINE_IDX_W-1:0] out_line_index,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int PACK_W = LINE_W - SAMPLE_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [LANE_W-1:0]       lane_cnt_q;
    logic [LINE_IDX_W-1:0]   line_cnt_q;
    logic [PACK_W-1:0]       pack_q;
    logic [LINE_W-1:0]       out_data_q;
    logic [LINE_IDX_W-1:0]   out_line_index_q;
    logic                    out_valid_q;
    logic                    frame_done_q;

    logic accept;
    logic drain;
    logic last_lane;
    logic last_line;

    assign last_lane = (lane_cnt_q == LANE_W'(SPL - 1));
    assign last_line = (line_cnt_q == LINE_IDX_W'(LPF - 1));
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid_q && out_ready;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start only in IDLE, frame ends on last sample, then flush line 63.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start)                             state_d = S_FILL;
            S_FILL:  if (accept && last_lane && last_line)  state_d = S_FLUSH;
            S_FLUSH: if (drain)                             state_d = S_IDLE;
            default:                                        state_d = S_IDLE;
        endcase
    end

    // Output decode: only lane 31 can stall, and only when the output line is stuck.
    always_comb begin
        busy     = (state_q != S_IDLE);
        in_ready = (state_q == S_FILL) && (!last_lane || !out_valid_q || out_ready);
    end

    // Datapath: lane packing, line hand-off to the output register, drain and frame_done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_cnt_q       <= '0;
            line_cnt_q       <= '0;
            // NOTE: the pack register is wide but is still reset, so outputs are defined after reset.
            pack_q           <= '0;
            out_data_q       <= '0;
            out_line_index_q <= '0;
            out_valid_q      <= 1'b0;
            frame_done_q     <= 1'b0;
        end else begin
            frame_done_q <= (state_q == S_FLUSH) && drain;

            // Drain first; a line loaded on the same edge overrides it (no bubble).
            if (drain) begin
                out_valid_q <= 1'b0;
            end

            if (accept) begin
                if (!last_lane) begin
                    for (int j = 0; j < SPL - 1; j++) begin
                        if (lane_cnt_q == LANE_W'(j)) begin
                            pack_q[j*SAMPLE_W +: SAMPLE_W] <= in_data;
                        end
                    end
                    lane_cnt_q <= lane_cnt_q + LANE_W'(1);
                end else begin
                    out_data_q       <= {in_data, pack_q};
                    out_line_index_q <= line_cnt_q;
                    out_valid_q      <= 1'b1;
                    lane_cnt_q       <= '0;
                    line_cnt_q       <= line_cnt_q + LINE_IDX_W'(1);
                end
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_line_index = out_line_index_q;
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_fft_output_packer.sv
// Testbench for fft_output_packer: directed frames with a scoreboard of expected lines.
module tb_fft_output_packer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_data;
    logic [5:0]   out_line_index;
    logic         busy;
    logic         frame_done;

    always #5 clk = ~clk;

    fft_output_packer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_line_index (out_line_index),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [511:0] data;
        logic [5:0]   idx;
    } exp_t;

    exp_t         exp_q[$];
    logic [511:0] line_m;
    int           lane_m     = 0;
    int           idx_m      = 0;
    int           lines_out  = 0;
    int           fd_cnt     = 0;
    bit           hold_prev  = 1'b0;
    logic [511:0] data_prev;
    logic [5:0]   idx_prev;
    bit           load_prev  = 1'b0;
    logic [5:0]   load_idx;
    int           n;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_line(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bench model and scoreboard: build expected lines from accepted samples, compare drains.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (hold_prev) begin
                chk("hold_valid", out_valid, 1);
                chk_line("hold_data", out_data, data_prev);
                chk("hold_idx", out_line_index, idx_prev);
            end
            if (load_prev) begin
                chk("load_latency_valid", out_valid, 1);
                chk("load_latency_idx", out_line_index, load_idx);
            end
            if (out_valid && out_ready) begin
                chk("sb_has_entry", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk_line("line_data", out_data, e.data);
                    chk("line_idx", out_line_index, e.idx);
                end
                lines_out++;
            end
            load_prev = 1'b0;
            if (in_valid && in_ready) begin
                line_m[lane_m*16 +: 16] = in_data;
                if (lane_m == 31) begin
                    e.data = line_m;
                    e.idx  = 6'(idx_m);
                    exp_q.push_back(e);
                    load_prev = 1'b1;
                    load_idx  = 6'(idx_m);
                    idx_m     = (idx_m + 1) % 64;
                    lane_m    = 0;
                end else begin
                    lane_m++;
                end
            end
            if (frame_done) fd_cnt++;
            hold_prev = out_valid && !out_ready;
            data_prev = out_data;
            idx_prev  = out_line_index;
        end else begin
            hold_prev = 1'b0;
            load_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed samples n..target-1, optionally with random in_valid gaps and random out_ready.
    task automatic feed(input int target, input bit rnd_valid, input bit rnd_ready, input int budget);
        bit acc;
        int k = 0;
        while (n < target && k < budget) begin
            in_valid  = rnd_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_data   = 16'(n);
            out_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) n++;
            k++;
        end
        in_valid = 1'b0;
        chk("feed_reached_target", n, target);
    endtask

    // Wait (bounded) for frame_done; optionally pulse start in that same cycle.
    task automatic wait_frame_done(input int budget, input bit rnd_ready, input bit start_on_done);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            out_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                if (start_on_done) start = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        chk("frame_done_seen", seen, 1);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        start    = 1'b0;
        tick();
        exp_q.delete();
        lane_m = 0;
        idx_m  = 0;
        line_m = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0, lo0, stalls, vmis;
        line_m = '0;

        // T1: reset held two cycles with in_valid and start high.
        rst_n     = 1'b0;
        start     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'hFFFF;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_line_index", out_line_index, 0);
        chk_line("rst_out_data", out_data, '0);
        start    = 1'b0;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        // T2: full frame at one sample per cycle, out_ready high.
        pulse_start();
        chk("t2_busy", busy, 1);
        fd0 = fd_cnt; lo0 = lines_out; stalls = 0; vmis = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            @(negedge clk);
            if (!in_ready) stalls++;
            if (out_valid !== ((i > 0) && (i % 32 == 0))) vmis++;
            tick();
        end
        in_valid = 1'b0;
        chk("t2_in_ready_stalls", stalls, 0);
        chk("t2_out_valid_cadence", vmis, 0);
        wait_frame_done(16, 1'b0, 1'b0);
        repeat (3) tick();
        chk("t2_frame_done_once", fd_cnt - fd0, 1);
        chk("t2_lines", lines_out - lo0, 64);
        chk("t2_sb_drained", exp_q.size(), 0);
        chk("t2_idle", busy, 0);

        // T3: backpressure from line 0; lane 31 of line 1 is the first stall.
        pulse_start();
        fd0 = fd_cnt; lo0 = lines_out; stalls = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 200; k++) begin
            in_valid = 1'b1;
            in_data  = 16'(n);
            @(negedge clk);
            if (!in_ready) break;
            tick();
            n++;
        end
        chk("t3_first_stall_sample", n, 63);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (in_ready) stalls++;
            tick();
        end
        chk("t3_stall_held", stalls, 0);
        chk("t3_lane0", out_data[15:0], 16'h0000);
        chk("t3_held_idx", out_line_index, 0);
        feed(2048, 1'b0, 1'b0, 4000);
        wait_frame_done(16, 1'b0, 1'b0);
        repeat (2) tick();
        chk("t3_frame_done_once", fd_cnt - fd0, 1);
        chk("t3_lines", lines_out - lo0, 64);
        chk("t3_sb_drained", exp_q.size(), 0);

        // T4: random input gaps and random downstream readiness.
        pulse_start();
        fd0 = fd_cnt; lo0 = lines_out;
        feed(2048, 1'b1, 1'b1, 20000);
        wait_frame_done(400, 1'b1, 1'b0);
        out_ready = 1'b1;
        repeat (2) tick();
        chk("t4_frame_done_once", fd_cnt - fd0, 1);
        chk("t4_lines", lines_out - lo0, 64);
        chk("t4_sb_drained", exp_q.size(), 0);

        // T5: reset after sample 1000, then a clean frame.
        pulse_start();
        fd0 = fd_cnt;
        feed(1001, 1'b0, 1'b1, 5000);
        out_ready = 1'b0;
        do_reset();
        chk("t5_out_valid", out_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_in_ready", in_ready, 0);
        chk("t5_line_index", out_line_index, 0);
        rst_n = 1'b1;
        tick();
        chk("t5_no_frame_done", fd_cnt - fd0, 0);
        pulse_start();
        lo0 = lines_out;
        feed(2048, 1'b0, 1'b0, 4000);
        wait_frame_done(16, 1'b0, 1'b0);
        repeat (2) tick();
        chk("t5_frame_done_once", fd_cnt - fd0, 1);
        chk("t5_lines", lines_out - lo0, 64);

        // T6: start during FILL is ignored; start in the frame_done cycle is honoured.
        pulse_start();
        fd0 = fd_cnt; lo0 = lines_out;
        feed(100, 1'b0, 1'b0, 400);
        start = 1'b1;
        feed(140, 1'b1, 1'b0, 400);
        start = 1'b0;
        feed(2048, 1'b0, 1'b0, 4000);
        wait_frame_done(16, 1'b0, 1'b1);
        chk("t6_restart_busy", busy, 1);
        chk("t6_lines", lines_out - lo0, 64);
        n = 0;
        lo0 = lines_out;
        feed(2048, 1'b0, 1'b0, 4000);
        wait_frame_done(16, 1'b0, 1'b0);
        repeat (2) tick();
        chk("t6_frame_done_count", fd_cnt - fd0, 2);
        chk("t6_second_lines", lines_out - lo0, 64);
        chk("t6_sb_drained", exp_q.size(), 0);
        chk("t6_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
